// File: rtl/sram_1rw_req_adapter.sv
// sram_1rw_req_adapter
//
// Request/response front end for a single-port synchronous-read SRAM
// (read data appears on sram_datar one cycle after ce). A valid/ready
// request stream is turned into SRAM strobes with zero latency. Read data is
// either handed straight to the response port (bypass) or captured into a
// small in-order buffer before the next ce overwrites the SRAM output.
//
// Optional feature macro: SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
//   defined   : writes also take a credit and return an in-order response
//               with rsp_wr=1 and rsp_rdata=0 (rsp_wr port present)
//   undefined : writes are fire-and-forget, no rsp_wr port
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_we/addr/wdata      request command, address, write data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              response data
//   rsp_wr                 response is a write ack (optional feature only)
//   sram_addr/ce/we/dataw  strobes to the SRAM macro
//   sram_datar             read data from the SRAM macro
//
// RSP_DEPTH must be >= 2; 2 sustains one read per cycle.

module sram_1rw_req_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1024,
    parameter int RSP_DEPTH  = 2,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
    output logic                  rsp_wr,
`endif
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [DATA_WIDTH-1:0] sram_dataw,
    input  logic [DATA_WIDTH-1:0] sram_datar
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_mem [RSP_DEPTH];

    logic                  fire;
    logic                  buf_empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] bypass_data;

`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
    logic inflight_wr_q, inflight_wr_d;
    logic buf_wr_mem [RSP_DEPTH];
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal written in this block gets a default first, so no
    // path through the block can leave a value held and infer a latch.
    always_comb begin
        // Credit is derived from registered state only, so the upstream
        // can never form a combinational loop through valid -> ready.
        req_ready = (int'(cnt_q) + int'(inflight_q)) < RSP_DEPTH;
        fire      = req_valid & req_ready;

        sram_ce    = fire;
        sram_we    = fire & req_we;
        sram_addr  = req_addr;
        sram_dataw = req_wdata;

        buf_empty   = (cnt_q == '0);
        bypass_data = sram_datar;
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
        // A write ack travels the read path but carries zero data.
        if (inflight_wr_q) bypass_data = '0;
        rsp_wr = buf_empty ? inflight_wr_q : buf_wr_mem[head_q];
        inflight_wr_d = fire & req_we;
        inflight_d    = fire;
`else
        inflight_d    = fire & ~req_we;
`endif

        rsp_valid = ~buf_empty | inflight_q;
        rsp_rdata = buf_empty ? bypass_data : buf_mem[head_q];

        // Older buffered entries drain first; the SRAM output is only
        // consumed directly when nothing is queued ahead of it. Otherwise it
        // must be captured now, since any ce this cycle replaces it.
        pop  = ~buf_empty & rsp_ready;
        push = inflight_q & ~(buf_empty & rsp_ready);

        head_d = pop  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_wr_q <= 1'b0;
        else     inflight_wr_q <= inflight_wr_d;
    end
`endif

    // NOTE: the buffer storage has no reset; an entry is only ever read
    // after it was written, and cnt_q/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[tail_q] <= bypass_data;
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
            buf_wr_mem[tail_q] <= inflight_wr_q;
`endif
        end
    end

    // The credit rule makes a push into a full buffer unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && cnt_q == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_sram_1rw_req_adapter.sv
module tb_sram_1rw_req_adapter;

    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int RD    = 2;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_ce;
    logic          sram_we;
    logic [DW-1:0] sram_dataw;
    logic [DW-1:0] sram_datar;
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
    logic          rsp_wr;
`endif

    int total;
    int bad;

    sram_1rw_req_adapter #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
        .rsp_wr     (rsp_wr),
`endif
        .sram_addr  (sram_addr),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_dataw (sram_dataw),
        .sram_datar (sram_datar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: read-before-write, any ce refreshes datar.
    logic          preload;
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= DW'(i);
        end else if (sram_ce) begin
            sram_datar <= sram_mem[sram_addr];
            if (sram_we) sram_mem[sram_addr] <= sram_dataw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic rr);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = rr;
    endtask

    task automatic do_preload();
        @(negedge clk);
        drive(0, 0, '0, '0, 0);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_rdy;
        logic          e_ce;
        logic          e_we;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
    } rsp_t;

    vec_t          vecs [17];
    rsp_t          exp_q [$];
    logic [DW-1:0] ref_mem [DEPTH];

    initial begin
        total = 0;
        bad   = 0;
        preload = 1'b0;
        drive(0, 0, '0, '0, 0);

        //          v  we addr    wd     rr rdy ce we rv rd
        vecs[0]  = '{1, 1, 10'h005, 8'hA5, 1, 1, 1, 1, 0, 8'h00};
        vecs[1]  = '{1, 0, 10'h005, 8'h00, 1, 1, 1, 0, 0, 8'h00};
        vecs[2]  = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 1, 8'hA5};
        vecs[3]  = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 0, 8'h00};
        vecs[4]  = '{1, 0, 10'h001, 8'h00, 0, 1, 1, 0, 0, 8'h00};
        vecs[5]  = '{1, 0, 10'h002, 8'h00, 0, 1, 1, 0, 1, 8'h01};
        vecs[6]  = '{1, 0, 10'h009, 8'h00, 0, 0, 0, 0, 1, 8'h01};
        vecs[7]  = '{0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 1, 8'h01};
        vecs[8]  = '{0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 1, 8'h01};
        vecs[9]  = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 1, 8'h02};
        vecs[10] = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 0, 8'h00};
        vecs[11] = '{1, 0, 10'h003, 8'h00, 0, 1, 1, 0, 0, 8'h00};
        vecs[12] = '{1, 1, 10'h003, 8'h77, 0, 1, 1, 1, 1, 8'h03};
        vecs[13] = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 1, 8'h03};
        vecs[14] = '{1, 0, 10'h003, 8'h00, 1, 1, 1, 0, 0, 8'h00};
        vecs[15] = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 1, 8'h77};
        vecs[16] = '{0, 0, 10'h000, 8'h00, 1, 1, 0, 0, 0, 8'h00};

        // Reset and preload memory with data = low address bits.
        rst = 1'b1;
        preload = 1'b1;
        @(negedge clk);
        @(negedge clk);
        preload = 1'b0;
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset sram_ce",   32'(sram_ce),   32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifndef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
        // Directed table: write/read, backpressure, read-then-write hazard.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rr);
            #1;
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d sram_ce",   i), 32'(sram_ce),   32'(vecs[i].e_ce));
            check($sformatf("vec%0d sram_we",   i), 32'(sram_we),   32'(vecs[i].e_we));
            check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                check($sformatf("vec%0d rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rd));
            if (vecs[i].e_ce) begin
                check($sformatf("vec%0d sram_addr", i), 32'(sram_addr), 32'(vecs[i].addr));
                if (vecs[i].e_we)
                    check($sformatf("vec%0d sram_dataw", i), 32'(sram_dataw), 32'(vecs[i].wd));
            end
        end

        // Back-to-back reads 0x010..0x01F with rsp_ready held high.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(i < 16, 0, AW'(32'h10 + i), '0, 1);
            #1;
            if (i < 16) begin
                check($sformatf("b2b%0d req_ready", i), 32'(req_ready), 32'd1);
                check($sformatf("b2b%0d sram_ce", i), 32'(sram_ce), 32'd1);
            end
            if (i > 0 && i < 17) begin
                check($sformatf("b2b%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
                check($sformatf("b2b%0d rsp_rdata", i), 32'(rsp_rdata), 32'h10 + i - 1);
            end else begin
                check($sformatf("b2b%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            end
        end
`else
        // Write ack: write 0x020 := 0x3C, then read 0x020.
        do_preload();
        @(negedge clk);
        drive(1, 1, 10'h020, 8'h3C, 1);
        #1;
        check("ack write sram_we", 32'(sram_we), 32'd1);
        @(negedge clk);
        drive(1, 0, 10'h020, 8'h00, 1);
        #1;
        check("ack rsp_valid 1", 32'(rsp_valid), 32'd1);
        check("ack rsp_wr 1",    32'(rsp_wr),    32'd1);
        check("ack rsp_rdata 1", 32'(rsp_rdata), 32'h00);
        @(negedge clk);
        drive(0, 0, '0, '0, 1);
        #1;
        check("ack rsp_valid 2", 32'(rsp_valid), 32'd1);
        check("ack rsp_wr 2",    32'(rsp_wr),    32'd0);
        check("ack rsp_rdata 2", 32'(rsp_rdata), 32'h3C);
        @(negedge clk);
        drive(0, 0, '0, '0, 1);
        #1;
        check("ack drained", 32'(rsp_valid), 32'd0);
`endif

        // Reset mid-operation with two reads outstanding.
        @(negedge clk);
        drive(1, 0, 10'h001, '0, 0);
        @(negedge clk);
        drive(1, 0, 10'h002, '0, 0);
        @(negedge clk);
        drive(0, 0, '0, '0, 0);
        #2;
        check("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        check("pre-reset req_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("async reset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, '0, '0, 1);
            #1;
            check($sformatf("post-reset%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("post-reset%0d req_ready", i), 32'(req_ready), 32'd1);
        end

        // Random traffic against an abstract model: a memory array plus a
        // queue of owed responses. Outstanding = accepted but not consumed.
        do_preload();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic          v, we, rr, exp_rdy, exp_rv, fire;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            rsp_t          r;
            @(negedge clk);
            v  = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 2) == 0;
            a  = AW'($urandom_range(0, 15));
            wd = DW'($urandom);
            rr = ($urandom_range(0, 9) < 6);
            drive(v, we, a, wd, rr);
            #1;
            exp_rdy = exp_q.size() < RD;
            exp_rv  = exp_q.size() != 0;
            fire    = v & exp_rdy;
            check("rnd req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rnd rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("rnd sram_ce",   32'(sram_ce),   32'(fire));
            check("rnd sram_we",   32'(sram_we),   32'(fire & we));
            if (exp_rv) begin
                check("rnd rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].d));
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
                check("rnd rsp_wr", 32'(rsp_wr), 32'(exp_q[0].wr));
`endif
                if (rr) void'(exp_q.pop_front());
            end
            if (fire) begin
                if (we) begin
                    ref_mem[a] = wd;
`ifdef SRAM_1RW_REQ_ADAPTER_WRITE_ACK_EN
                    r.wr = 1'b1;
                    r.d  = '0;
                    exp_q.push_back(r);
`endif
                end else begin
                    r.wr = 1'b0;
                    r.d  = ref_mem[a];
                    exp_q.push_back(r);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
